water_fill_arbiter: RTL and testbench
=====================================

# water_fill_arbiter

Round-robin arbiter that shares the single building water-inlet valve among N washing-machine controllers. Each machine raises a fill request at the start of its fill phase. The arbiter grants the valve to one machine at a time, inserts a one-cycle switch-over gap between grants, and can optionally revoke a grant that exceeds a maximum fill time measured in seconds. Seconds are derived from the same `clk_freq` encoding the washer controllers use.

## Interface
- `N`, 4: number of requesting machines, ≥2
- `BASE_DIV`, 1000000: clock cycles per second at 1 MHz (benches override with a small value)
- `MAX_FILL_SEC`, 60: maximum grant duration in seconds (used only with the timeout feature); ≥1
- `clk` in 1: single system clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `clk_freq` in 2: clock-rate select; 00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz; cycles per second = `BASE_DIV` × {1,2,4,8}
- `timer_pause` in 1: freezes grant timing while high; the grant is held
- `req` in N: level fill request per machine
- `grant` out N: one-hot (or zero) valve grant, registered
- `grant_id` out clog2(N): index of the current holder; holds the last value when idle
- `valve_on` out 1: OR of `grant`, registered
- `timeout` out N: one-cycle pulse on forced revocation (zero when the macro is absent)

## Operation
- States: IDLE, GRANT, RELEASE.
- **IDLE:**
  - If any eligible `req` bit is sampled high, pick the first eligible index scanning upward from `ptr+1` (mod N).
  - Next cycle: `grant` = that one-hot value, `grant_id` = that index, `valve_on`=1, `ptr` = that index. Go to GRANT.
- **GRANT:**
  - Hold while `req[grant_id]` is high.
  - If `req[grant_id]` is sampled low: go to RELEASE and drop `grant`/`valve_on` next cycle.
- **RELEASE:**
  - Exactly one cycle with `grant`=0.
  - Arbitration is performed in this cycle as in IDLE, so the next holder's grant appears in the following cycle. Otherwise go to IDLE.
- Eligible = `req` high and not locked out. Lockout exists only with the timeout feature.
- Round-robin pointer `ptr` resets to N−1, so index 0 has first priority after reset.
- Simultaneous requests: one winner per arbitration. Others wait without loss; `req` is a level.
- A request dropped before it is granted is simply not served.
- Reset mid-grant: outputs clear asynchronously, state returns to IDLE, `ptr`=N−1, lockouts and counters clear.
- Reset values: `grant`=0, `grant_id`=0, `valve_on`=0, `timeout`=0.

## Timing
- Request-to-grant latency: 1 cycle from the edge sampling `req` in IDLE or RELEASE.
- Release-to-next-grant gap: exactly one all-zero `grant` cycle.
- **Seconds prescaler:**
  - Counts cycles only while in GRANT with `timer_pause` low.
  - Clears on grant start and whenever `clk_freq` changes.
  - A tick at terminal count (`BASE_DIV`×mult − 1) wraps the prescaler to 0 and increments the second counter.
- **Second counter:**
  - Clears on grant start; frozen while paused.
  - Width is clog2(`MAX_FILL_SEC`+1). It saturates and never wraps.
- `timer_pause` high in IDLE/RELEASE has no effect on arbitration.

## Configuration
- Macro: `WATER_FILL_TIMEOUT_EN`.
- **Defined:**
  - When the second counter reaches `MAX_FILL_SEC` in GRANT, go to RELEASE.
  - Next cycle: `grant`=0 and `timeout[grant_id]` pulses high for 1 cycle.
  - The lockout bit for that index is set and stays set until its `req` is sampled low.
  - If `req` drops on the same edge as the timeout, the timeout still fires and the lockout clears next cycle.
- **Undefined:**
  - No prescaler, counter or lockout logic.
  - `timeout` is tied to 0, and a grant lasts as long as `req`.
  - `timer_pause` and `clk_freq` are unused.

## Structure
- Shared package `washer_pkg`:
  - state enum (IDLE, GRANT, RELEASE)
  - `clk_freq` encoding constants and the multiplier function {1,2,4,8}
- Sub-module `sec_tick_gen`:
  - inputs: `clk`, `rst_n`, `clk_freq`, `enable`, `clear`
  - output: one-cycle `sec_tick`
  - parameter: `BASE_DIV`
  - Reused by the washer controllers.

## Test plan
All scenarios use `N`=4, `BASE_DIV`=10, `MAX_FILL_SEC`=3, macro defined unless stated.

- **Reset, single request:** after reset, raise `req`=0001 → `grant`=0001 and `grant_id`=0 one cycle later; drop `req` → one zero cycle, then IDLE.
- **Round robin:** hold `req`=1111 and drop each holder after 5 cycles → grant order 0,1,2,3,0, each separated by exactly one zero-grant cycle.
- **Timeout at 1 MHz:** `clk_freq`=00, hold `req[1]` → `grant[1]` high exactly 30 cycles, then `timeout`=0010 pulse. `req[1]` is not re-granted until it goes low for ≥1 cycle.
- **Timeout at 8 MHz with pause:** `clk_freq`=11, hold `req[2]` with `timer_pause` high for 50 cycles mid-grant → grant lasts 240+50 cycles before `timeout`=0100.
- **Reset mid-grant:** assert `rst_n`=0 while `grant`=1000 → `grant`, `valve_on` and `timeout` go 0 immediately; after release with `req`=1111, the first grant is 0001.
- **Macro undefined:** hold `req[0]` for 500 cycles → `grant` stays 0001 and `timeout` never pulses.

Source files
------------

// File: rtl/washer_pkg.sv
// washer_pkg: definitions shared by the washer controllers and the water-fill arbiter.
//   state_e   - arbiter FSM states (IDLE, GRANT, RELEASE)
//   FREQ_*    - clk_freq encodings (1/2/4/8 MHz)
//   freq_mult - cycles-per-second multiplier for a clk_freq code
package washer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] FREQ_1MHZ = 2'b00;
  localparam logic [1:0] FREQ_2MHZ = 2'b01;
  localparam logic [1:0] FREQ_4MHZ = 2'b10;
  localparam logic [1:0] FREQ_8MHZ = 2'b11;

  function automatic int unsigned freq_mult(input logic [1:0] sel);
    case (sel)
      FREQ_1MHZ: return 1;
      FREQ_2MHZ: return 2;
      FREQ_4MHZ: return 4;
      default:   return 8;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: seconds prescaler. Counts enabled cycles and emits a one-cycle
// sec_tick every BASE_DIV*freq_mult(clk_freq) enabled cycles.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clk_freq    - clock-rate select (washer_pkg encoding)
//   enable      - count this cycle
//   clear       - restart the second from zero (wins over enable)
//   sec_tick    - combinational pulse in the cycle the terminal count is reached
module sec_tick_gen
  import washer_pkg::*;
#(
  parameter int BASE_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] clk_freq,
  input  logic       enable,
  input  logic       clear,
  output logic       sec_tick
);

  localparam int CW = $clog2(BASE_DIV * 8);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] term;
  logic [1:0]    freq_q;
  logic          freq_chg;

  assign term     = CW'(BASE_DIV * freq_mult(clk_freq) - 1);
  // A rate change mid-second would leave the count meaningless, so restart it.
  assign freq_chg = (clk_freq != freq_q);

  always_comb begin
    cnt_d    = cnt_q;
    sec_tick = 1'b0;
    if (clear || freq_chg) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == term) begin
        cnt_d    = '0;
        sec_tick = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      freq_q <= FREQ_1MHZ;
    end else begin
      cnt_q  <= cnt_d;
      freq_q <= clk_freq;
    end
  end

endmodule

// File: rtl/water_fill_arbiter.sv
// water_fill_arbiter: round-robin owner of the shared water-inlet valve.
// One machine holds the valve at a time; every hand-over has a one-cycle
// all-zero grant gap. Optional macro WATER_FILL_TIMEOUT_EN adds a maximum
// fill time (MAX_FILL_SEC seconds) with forced revocation and lockout.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clk_freq     - clock-rate select for the seconds prescaler
//   timer_pause  - freezes fill timing while high (grant is held)
//   req[N]       - level fill requests
//   grant[N]     - registered one-hot valve grant
//   grant_id     - index of current/last holder
//   valve_on     - registered OR of grant
//   timeout[N]   - one-cycle pulse on forced revocation
module water_fill_arbiter
  import washer_pkg::*;
#(
  parameter int N            = 4,
  parameter int BASE_DIV     = 1000000,
  parameter int MAX_FILL_SEC = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           clk_freq,
  input  logic                 timer_pause,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 valve_on,
  output logic [N-1:0]         timeout
);

  localparam int IW = $clog2(N);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          valve_on_q, valve_on_d;

  logic [N-1:0]  eligible;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          expire;

`ifdef WATER_FILL_TIMEOUT_EN
  localparam int SW = $clog2(MAX_FILL_SEC + 1);

  logic [SW-1:0] sec_cnt_q, sec_cnt_d, sec_next;
  logic [N-1:0]  lockout_q, lockout_d;
  logic [N-1:0]  timeout_q, timeout_d;
  logic [N-1:0]  holder_bit;
  logic          sec_tick;
  logic          grant_start;

  assign grant_start = (state_q != GRANT) && found;

  sec_tick_gen #(.BASE_DIV(BASE_DIV)) u_sec_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_freq (clk_freq),
    .enable   ((state_q == GRANT) && !timer_pause),
    .clear    (grant_start),
    .sec_tick (sec_tick)
  );

  always_comb begin
    sec_next = sec_cnt_q;
    if (sec_tick && (sec_cnt_q != SW'(MAX_FILL_SEC))) sec_next = sec_cnt_q + 1'b1;
    sec_cnt_d = grant_start ? '0 : sec_next;
  end

  // Revoke on the edge where the count reaches the limit, so the grant lasts
  // exactly MAX_FILL_SEC seconds of unpaused time.
  assign expire = (state_q == GRANT) && (sec_next == SW'(MAX_FILL_SEC));

  always_comb begin
    holder_bit             = '0;
    holder_bit[grant_id_q] = 1'b1;
    timeout_d              = expire ? holder_bit : '0;
    // Lockout releases once the request is seen low; a fresh revocation wins.
    lockout_d              = (lockout_q & req) | timeout_d;
  end

  assign eligible = req & ~lockout_q;
  assign timeout  = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q <= '0;
      lockout_q <= '0;
      timeout_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      lockout_q <= lockout_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{timer_pause, clk_freq};
  assign expire     = 1'b0;
  assign eligible   = req;
  assign timeout    = '0;
`endif

  // Round-robin pick: first eligible index scanning upward from ptr+1.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= IW'(N - 1);
      valve_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      valve_on_q <= valve_on_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GRANT:   if (expire || !req[grant_id_q]) state_d = RELEASE;
      default: state_d = found ? GRANT : IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    valve_on_d = valve_on_q;
    case (state_q)
      GRANT: begin
        if (expire || !req[grant_id_q]) begin
          grant_d    = '0;
          valve_on_d = 1'b0;
        end
      end
      default: begin
        grant_d    = '0;
        valve_on_d = found;
        if (found) begin
          grant_d[pick] = 1'b1;
          grant_id_d    = pick;
          ptr_d         = pick;
        end
      end
    endcase
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign valve_on = valve_on_q;

endmodule

// File: tb/tb_water_fill_arbiter.sv
module tb_water_fill_arbiter;
  localparam int N            = 4;
  localparam int BASE_DIV     = 10;
  localparam int MAX_FILL_SEC = 3;
`ifdef WATER_FILL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   clk_freq = 2'b00;
  logic         timer_pause = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant, timeout;
  logic [1:0]   grant_id;
  logic         valve_on;

  int checks = 0;
  int failures = 0;

  // Reference model: who holds the valve, how long it has filled, who is locked out.
  int           m_holder, m_ptr, m_elapsed, m_gid;
  logic [N-1:0] m_lock, m_grant, m_timeout;
  logic         m_valve;

  always #5 clk = ~clk;

  water_fill_arbiter #(.N(N), .BASE_DIV(BASE_DIV), .MAX_FILL_SEC(MAX_FILL_SEC)) dut (
    .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .timer_pause(timer_pause),
    .req(req), .grant(grant), .grant_id(grant_id), .valve_on(valve_on), .timeout(timeout)
  );

  task automatic model_reset();
    m_holder = -1; m_ptr = N - 1; m_elapsed = 0; m_gid = 0;
    m_lock = '0; m_grant = '0; m_timeout = '0; m_valve = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] set_lock;
    int el, limit;
    set_lock  = '0;
    m_timeout = '0;
    if (m_holder >= 0) begin
      el    = m_elapsed + (timer_pause ? 0 : 1);
      limit = MAX_FILL_SEC * BASE_DIV * (1 << clk_freq);
      if (TO_EN && el >= limit) begin
        m_timeout[m_holder] = 1'b1;
        set_lock[m_holder]  = 1'b1;
        m_holder = -1;
      end else if (!req[m_holder]) begin
        m_holder = -1;
      end else begin
        m_elapsed = el;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req[i] && !m_lock[i]) begin
          m_holder = i; m_ptr = i; m_gid = i; m_elapsed = 0;
          break;
        end
      end
    end
    m_lock  = (m_lock & req) | set_lock;
    m_grant = '0;
    if (m_holder >= 0) m_grant[m_holder] = 1'b1;
    m_valve = (m_holder >= 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; timer_pause = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; timer_pause = 1'b0; clk_freq = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
    checks++; if (valve_on !== 1'b0) begin failures++; $display("FAIL reset_valve got=%b want=0", valve_on); end
    checks++; if (timeout !== 4'b0000) begin failures++; $display("FAIL reset_timeout got=%b want=0000", timeout); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0001;
    step();
    checks++; if (grant !== 4'b0001 || grant_id !== 2'd0 || valve_on !== 1'b1) begin
      failures++; $display("FAIL single_grant got=%b/%0d/%b want=0001/0/1", grant, grant_id, valve_on); end
    req = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000 || valve_on !== 1'b0) begin
      failures++; $display("FAIL single_release got=%b/%b want=0000/0", grant, valve_on); end
    step();
    checks++; if (grant !== 4'b0000 || grant_id !== 2'd0) begin
      failures++; $display("FAIL single_idle got=%b/%0d want=0000/0", grant, grant_id); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int held = 0;
    logic [N-1:0] prev = '0;
    do_reset();
    req = 4'b1111;
    for (int cyc = 0; cyc < 100 && order.size() < 5; cyc++) begin
      step();
      checks++; if (grant !== m_grant || grant_id !== 2'(m_gid)) begin
        failures++; $display("FAIL rr_cycle got=%b/%0d want=%b/%0d", grant, grant_id, m_grant, m_gid); end
      if (grant !== '0 && grant !== prev) begin
        checks++; if (prev !== '0) begin
          failures++; $display("FAIL rr_gap prev=%b now=%b want prev=0000", prev, grant); end
        order.push_back(int'(grant_id));
      end
      prev = grant;
      if (m_holder >= 0) begin
        held++;
        if (held == 5) req[m_holder] = 1'b0;
      end else begin
        held = 0;
        req = 4'b1111;
      end
    end
    checks++; if (order.size() != 5) begin
      failures++; $display("FAIL rr_order_len got=%0d want=5", order.size()); end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      checks++; if (order[i] != exp_order[i]) begin
        failures++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]); end
    end
  endtask

`ifdef WATER_FILL_TIMEOUT_EN
  task automatic test_timeout_1mhz();
    int hi = 0;
    bit seen = 1'b0;
    clk_freq = 2'b00;
    do_reset();
    req = 4'b0010;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      step();
      checks++; if (grant !== m_grant || timeout !== m_timeout) begin
        failures++; $display("FAIL to1_cycle got=%b/%b want=%b/%b", grant, timeout, m_grant, m_timeout); end
      if (grant[1]) hi++;
      if (timeout !== 4'b0000) begin
        seen = 1'b1;
        checks++; if (timeout !== 4'b0010) begin
          failures++; $display("FAIL to1_pulse got=%b want=0010", timeout); end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL to1_seen got=0 want=1"); end
    checks++; if (hi != 30) begin failures++; $display("FAIL to1_len got=%0d want=30", hi); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      checks++; if (grant !== 4'b0000 || timeout !== 4'b0000) begin
        failures++; $display("FAIL to1_lockout got=%b/%b want=0000/0000", grant, timeout); end
    end
    req = 4'b0000;
    step();
    req = 4'b0010;
    step();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL to1_regrant got=%b want=0010", grant); end
  endtask

  task automatic test_timeout_8mhz_pause();
    int hi = 0;
    bit seen = 1'b0;
    clk_freq = 2'b11;
    do_reset();
    req = 4'b0100;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      step();
      checks++; if (grant !== m_grant || timeout !== m_timeout) begin
        failures++; $display("FAIL to8_cycle got=%b/%b want=%b/%b", grant, timeout, m_grant, m_timeout); end
      if (grant[2]) begin
        hi++;
        if (hi == 100) timer_pause = 1'b1;
        if (hi == 150) timer_pause = 1'b0;
      end
      if (timeout !== 4'b0000) begin
        seen = 1'b1;
        checks++; if (timeout !== 4'b0100) begin
          failures++; $display("FAIL to8_pulse got=%b want=0100", timeout); end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL to8_seen got=0 want=1"); end
    checks++; if (hi != 290) begin failures++; $display("FAIL to8_len got=%0d want=290", hi); end
    timer_pause = 1'b0;
    clk_freq = 2'b00;
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req = 4'b0001;
    step();
    for (int cyc = 0; cyc < 500; cyc++) begin
      timer_pause = cyc[3];
      step();
      checks++; if (grant !== 4'b0001 || timeout !== 4'b0000) begin
        failures++; $display("FAIL noto_hold got=%b/%b want=0001/0000", grant, timeout); end
    end
    timer_pause = 1'b0;
  endtask
`endif

  task automatic test_reset_midgrant();
    do_reset();
    req = 4'b1000;
    step();
    step();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL mid_pre got=%b want=1000", grant); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL mid_grant got=%b want=0000", grant); end
    checks++; if (valve_on !== 1'b0) begin failures++; $display("FAIL mid_valve got=%b want=0", valve_on); end
    checks++; if (timeout !== 4'b0000) begin failures++; $display("FAIL mid_timeout got=%b want=0000", timeout); end
    model_reset();
    req = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL mid_first got=%b want=0001", grant); end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 4; ep++) begin
      clk_freq = 2'($urandom_range(0, 3));
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 29) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 19) == 0) timer_pause = ~timer_pause;
        step();
        checks++;
        if (grant !== m_grant || grant_id !== 2'(m_gid) || valve_on !== m_valve || timeout !== m_timeout) begin
          failures++;
          $display("FAIL rand ep=%0d cyc=%0d got g=%b id=%0d v=%b to=%b want g=%b id=%0d v=%b to=%b",
                   ep, cyc, grant, grant_id, valve_on, timeout, m_grant, m_gid, m_valve, m_timeout);
        end
      end
    end
    timer_pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
`ifdef WATER_FILL_TIMEOUT_EN
    test_timeout_1mhz();
    test_timeout_8mhz_pause();
`else
    test_no_timeout();
`endif
    test_reset_midgrant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
